// File: rtl/clk_div_sequencer.sv
// clk_div_sequencer
//   Divided-clock generator whose divide ratio can be changed at run time
//   without producing a runt pulse. A new ratio is taken only in RUN. The
//   block then drains the old ratio up to the next clk_out rising boundary,
//   holds clk_out high for HOLD_CYCLES cycles, and loads the new ratio.
// Ports
//   clk_in    : sole clock, rising edge
//   rst       : asynchronous, active-high reset
//   req_valid : a new divisor is offered
//   req_div   : offered divisor (0 is treated as 1)
//   req_ready : request accepted when req_valid && req_ready
//   clk_out   : registered divided clock
//   tick      : one-cycle pulse on the clk_out 0->1 edge
//   done      : one-cycle pulse when the new divisor takes effect
//   busy      : high whenever the state is not RUN
//   cur_div   : divisor currently in effect
module clk_div_sequencer #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_div,
  output logic             req_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DEF_N = WIDTH'((DEFAULT_DIV == 0) ? 1 : DEFAULT_DIV);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HOLD, S_LOAD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic counting, wrap, rise, accept;

  assign counting = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wrap     = (cnt_q == div_q - WIDTH'(1));
  // 0->1 toggle of clk_out on this edge
  assign rise     = counting && wrap && !clk_q;
  assign accept   = req_valid && req_ready;

  // state register
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (accept) state_d = S_DRAIN;
      // Only reached from RUN, so a rise on the acceptance edge never ends DRAIN
      S_DRAIN: if (rise) state_d = (HOLD_CYCLES == 0) ? S_LOAD : S_HOLD;
      S_HOLD:  if (hold_q == HOLD_LAST) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // datapath / outputs
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    div_d  = div_q;
    pend_d = pend_q;
    hold_d = '0;
    tick_d = 1'b0;
    done_d = 1'b0;
    if (counting) begin
      if (wrap) begin
        cnt_d = '0;
        clk_d = ~clk_q;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      tick_d = rise;
    end
    if ((state_q == S_RUN) && accept)
      pend_d = (req_div == '0) ? WIDTH'(1) : req_div;
    if (state_q == S_HOLD) begin
      hold_d = hold_q + HW'(1);
      clk_d  = 1'b1;
    end
    if (state_q == S_LOAD) begin
      clk_d  = 1'b1;
      div_d  = pend_q;
      cnt_d  = '0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= DEF_N;
      pend_q <= DEF_N;
      hold_q <= '0;
      clk_q  <= 1'b1;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end

  assign req_ready = (state_q == S_RUN) && !rst;
  assign busy      = (state_q != S_RUN);
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign done      = done_q;
  assign cur_div   = div_q;

endmodule
